// File: rtl/cim_macro_array.sv
// cim_macro_array -- compute-in-memory weight array: 8 cores x 64 rows x 72
// four-bit weights, with a row-wide standard read/write port and a full
// 64-row multiply-accumulate that produces 72 fourteen-bit partial sums/cycle.
//
// Optional feature macro: CIM_SIGNED_EN
//   defined   -> weights/activations/PSUM are two's complement
//   undefined -> unsigned arithmetic (default)
//
// Ports
//   clk, rst_n       clock, async active-low reset (clears weight_out/PSUM only)
//   CIM_Core_A[2:0]  core feeding the MAC
//   STD_Core_A[2:0]  core for standard read/write
//   STDW, STDR       standard write / read enables (write wins)
//   STD_row_A[5:0]   row for standard read/write
//   weight_in[287:0] row write data, column c = [4c+3:4c]
//   act_in1/2/3      64 activations each, row r = [4r+3:4r]; feed column
//                    groups 0-23, 24-47, 48-71 respectively
//   weight_out       registered row read data
//   PSUM[1007:0]     registered partial sums, lane c = [14c+13:14c]

// One column's 64-term dot product.
module cim_lane (
  input  logic [63:0][3:0] w,
  input  logic [63:0][3:0] a,
  output logic [13:0]      sum
);
  logic [7:0] p;

  always_comb begin
    sum = '0;
    p   = '0;
    for (int r = 0; r < 64; r++) begin
`ifdef CIM_SIGNED_EN
      // -8*-8 = 64 still fits a signed byte, so 8-bit products are exact
      p   = 8'($signed({{4{w[r][3]}}, w[r]}) * $signed({{4{a[r][3]}}, a[r]}));
      sum = sum + {{6{p[7]}}, p};
`else
      p   = {4'b0, w[r]} * {4'b0, a[r]};
      sum = sum + {6'b0, p};
`endif
    end
  end
endmodule

module cim_macro_array (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    CIM_Core_A,
  input  logic [2:0]    STD_Core_A,
  input  logic          STDW,
  input  logic          STDR,
  input  logic [5:0]    STD_row_A,
  input  logic [287:0]  weight_in,
  input  logic [255:0]  act_in1,
  input  logic [255:0]  act_in2,
  input  logic [255:0]  act_in3,
  output logic [287:0]  weight_out,
  output logic [1007:0] PSUM
);
  localparam int NUM_LANES = 72;
  localparam int ROWS      = 64;

  // {core,row} flattened; not reset, contents undefined until written
  logic [287:0] mem [512];

  logic [ROWS-1:0][287:0]      core_rows;
  logic [NUM_LANES-1:0][13:0]  psum_d;
  logic [NUM_LANES-1:0][13:0]  psum_q;

  // Writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && STDW) mem[{STD_Core_A, STD_row_A}] <= weight_in;
  end

  // MAC core rows read combinationally, so a same-cycle write to the
  // same core is seen only from the next edge (read-before-write).
  always_comb begin
    core_rows = '0;
    for (int r = 0; r < ROWS; r++) core_rows[r] = mem[{CIM_Core_A, 6'(r)}];
  end

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    logic [ROWS-1:0][3:0] w_col;
    logic [255:0]         act_g;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign w_col[r] = core_rows[r][4*c +: 4];
    end

    if (c < 24) begin : g_grp1
      assign act_g = act_in1;
    end else if (c < 48) begin : g_grp2
      assign act_g = act_in2;
    end else begin : g_grp3
      assign act_g = act_in3;
    end

    cim_lane u_lane (
      .w   (w_col),
      .a   (act_g),
      .sum (psum_d[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_out <= '0;
      psum_q     <= '0;
    end else begin
      if (STDR && !STDW) weight_out <= mem[{STD_Core_A, STD_row_A}];
      psum_q <= psum_d;
    end
  end

  assign PSUM = psum_q;
endmodule

// File: tb/tb_cim_macro_array.sv
module tb_cim_macro_array;
  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    CIM_Core_A, STD_Core_A;
  logic          STDW, STDR;
  logic [5:0]    STD_row_A;
  logic [287:0]  weight_in;
  logic [255:0]  act_in1, act_in2, act_in3;
  logic [287:0]  weight_out;
  logic [1007:0] PSUM;

  cim_macro_array dut (
    .clk(clk), .rst_n(rst_n), .CIM_Core_A(CIM_Core_A), .STD_Core_A(STD_Core_A),
    .STDW(STDW), .STDR(STDR), .STD_row_A(STD_row_A), .weight_in(weight_in),
    .act_in1(act_in1), .act_in2(act_in2), .act_in3(act_in3),
    .weight_out(weight_out), .PSUM(PSUM)
  );

  always #5 clk = ~clk;

  // reference model: plain nibble array + written flags
  bit [3:0]     mm [512][72];
  bit           wr [512];
  logic [287:0] exp_wo;
  bit           wo_known;
  int           exp_ps [72];
  bit           ps_known;
  int           total = 0;
  int           bad   = 0;

  function automatic logic [287:0] rep_w(input logic [3:0] n);
    logic [287:0] v;
    for (int c = 0; c < 72; c++) v[4*c +: 4] = n;
    return v;
  endfunction

  function automatic logic [255:0] rep_a(input logic [3:0] n);
    logic [255:0] v;
    for (int r = 0; r < 64; r++) v[4*r +: 4] = n;
    return v;
  endfunction

  function automatic logic [255:0] rnd_a();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [287:0] rnd_w();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // sum over rows of weight * activation, interpreted per build mode
  function automatic int lane_exp(input int core, input int c);
    int s = 0;
    logic [255:0] a;
    a = (c < 24) ? act_in1 : (c < 48) ? act_in2 : act_in3;
    for (int r = 0; r < 64; r++) begin
      int w, x;
      w = int'(mm[core*64 + r][c]);
      x = int'(a[4*r +: 4]);
`ifdef CIM_SIGNED_EN
      if (w > 7) w -= 16;
      if (x > 7) x -= 16;
`endif
      s += w * x;
    end
    return s & 32'h3FFF;
  endfunction

  // advance one clock, updating the model with the values seen at the edge
  task automatic tick();
    bit full;
    int idx;
    @(posedge clk);
    if (!rst_n) begin
      exp_wo = '0; wo_known = 1;
      ps_known = 1;
      for (int c = 0; c < 72; c++) exp_ps[c] = 0;
    end else begin
      full = 1;
      for (int r = 0; r < 64; r++) if (!wr[int'(CIM_Core_A)*64 + r]) full = 0;
      ps_known = full;
      if (full) for (int c = 0; c < 72; c++) exp_ps[c] = lane_exp(int'(CIM_Core_A), c);
      idx = int'(STD_Core_A)*64 + int'(STD_row_A);
      if (STDR && !STDW) begin
        wo_known = wr[idx];
        for (int c = 0; c < 72; c++) exp_wo[4*c +: 4] = mm[idx][c];
      end
      if (STDW) begin
        for (int c = 0; c < 72; c++) mm[idx][c] = weight_in[4*c +: 4];
        wr[idx] = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk(input string tag);
    if (wo_known) begin
      total++;
      assert (weight_out === exp_wo) else begin
        bad++;
        $error("FAIL %s weight_out got=%h exp=%h", tag, weight_out, exp_wo);
      end
    end
    if (ps_known) begin
      for (int c = 0; c < 72; c++) begin
        total++;
        assert (PSUM[14*c +: 14] === 14'(exp_ps[c])) else begin
          bad++;
          $error("FAIL %s psum lane=%0d got=%0d exp=%0d", tag, c, PSUM[14*c +: 14], exp_ps[c]);
        end
      end
    end
  endtask

  task automatic chk_lane(input string tag, input int c, input int e);
    total++;
    assert (PSUM[14*c +: 14] === 14'(e)) else begin
      bad++;
      $error("FAIL %s lane=%0d got=%0d exp=%0d", tag, c, PSUM[14*c +: 14], e);
    end
  endtask

  task automatic fill(input int core, input logic [3:0] n);
    STDW = 1; STDR = 0; STD_Core_A = 3'(core); weight_in = rep_w(n);
    for (int i = 1; i <= 64; i++) begin
      STD_row_A = 6'(i % 64);
      tick();
      chk("fill");
    end
    STDW = 0;
  endtask

  initial begin
    rst_n = 0; CIM_Core_A = 0; STD_Core_A = 0; STDW = 0; STDR = 0;
    STD_row_A = 0; weight_in = '0;
    act_in1 = '0; act_in2 = '0; act_in3 = '0;
    for (int i = 0; i < 512; i++) wr[i] = 0;
    exp_wo = '0; wo_known = 1; ps_known = 1;
    for (int c = 0; c < 72; c++) exp_ps[c] = 0;
    repeat (2) @(negedge clk);
    chk("reset");
    rst_n = 1;

    // fill core 4 with 4'h1, rows 1..63 then 0
    CIM_Core_A = 4;
    fill(4, 4'h1);
    STDR = 1; STD_Core_A = 4; STD_row_A = 35;
    tick(); chk("read_c4_r35");
    STDR = 0;

    // MAC core 4 with acts 1 while core 3 is written
    act_in1 = rep_a(4'h1); act_in2 = rep_a(4'h1); act_in3 = rep_a(4'h1);
    fill(3, 4'h1);
    chk_lane("mac_ones", 0, 64);
    chk_lane("mac_ones", 71, 64);
    STDR = 1; STD_Core_A = 3; STD_row_A = 26;
    tick(); chk("read_c3_r26");
    STDR = 0;

    // column grouping
    act_in1 = rep_a(4'h2); act_in2 = rep_a(4'h0); act_in3 = rep_a(4'hF);
    tick(); chk("groups");
    chk_lane("grp1", 0, 128);
    chk_lane("grp2", 24, 0);
`ifdef CIM_SIGNED_EN
    chk_lane("grp3", 48, 16320);
`else
    chk_lane("grp3", 71, 960);
`endif

    // maximum value on core 5
    fill(5, 4'hF);
    CIM_Core_A = 5;
    act_in1 = rep_a(4'hF); act_in2 = rep_a(4'hF); act_in3 = rep_a(4'hF);
    tick(); chk("max");
`ifdef CIM_SIGNED_EN
    chk_lane("max", 35, 64);
`else
    chk_lane("max", 35, 14400);
`endif

    // same-core write during MAC: read-before-write
    CIM_Core_A = 4;
    act_in1 = rep_a(4'h1); act_in2 = rep_a(4'h1); act_in3 = rep_a(4'h1);
    STDW = 1; STD_Core_A = 4; STD_row_A = 0; weight_in = rep_w(4'h0);
    tick(); chk("rbw_old");
    chk_lane("rbw_old", 10, 64);
    STDW = 0;
    tick(); chk("rbw_new");
    chk_lane("rbw_new", 10, 63);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      CIM_Core_A = 3'(3 + $urandom_range(0, 2));
      STDW = ($urandom_range(0, 3) == 0);
      STDR = ($urandom_range(0, 1) == 1);
      STD_Core_A = 3'($urandom_range(0, 7));
      STD_row_A = 6'($urandom_range(0, 63));
      weight_in = rnd_w();
      act_in1 = rnd_a(); act_in2 = rnd_a(); act_in3 = rnd_a();
      tick(); chk("rand");
    end

    // mid-run reset: outputs clear at once, array keeps its data
    STDW = 0; STDR = 0;
    rst_n = 0;
    #1;
    exp_wo = '0; wo_known = 1; ps_known = 1;
    for (int c = 0; c < 72; c++) exp_ps[c] = 0;
    chk("async_rst");
    @(negedge clk);
    tick(); chk("in_rst");
    rst_n = 1;
    STDR = 1; STD_Core_A = 4; STD_row_A = 35; CIM_Core_A = 5;
    tick(); chk("post_rst_read");
    STDR = 0; STD_Core_A = 5; STD_row_A = 7; STDR = 1;
    tick(); chk("post_rst_read2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
